// File: rtl/gc_pkg.sv
// gc_pkg: shared state encoding and protocol constants for the GameCube poller.
// Bit-cell timing is in microseconds; the poller scales it by CLKS_PER_US.
package gc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_BIT  = 3'd1,
    TX_STOP = 3'd2,
    RX_WAIT = 3'd3,
    RX_BIT  = 3'd4,
    DONE    = 3'd5
  } gc_state_t;

  localparam logic [23:0] GC_POLL_CMD = 24'h400300;
  localparam int GC_CMD_BITS = 24;

  localparam int GC_SHORT_US = 1;
  localparam int GC_HALF_US  = 2;
  localparam int GC_LONG_US  = 3;
  localparam int GC_CELL_US  = 4;

  localparam int GC_RESP_BITS = 64;

endpackage

// File: rtl/gc_sync.sv
// gc_sync: two-flop synchronizer for the controller data line
// plus a falling-edge detector on the synchronized value.
module gc_sync (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_s,
  output logic fall
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= data_in;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign data_s = s2;
  assign fall   = s2_d & ~s2;

endmodule

// File: rtl/gc_poller.sv
// gc_poller: polls a GameCube controller over its open-drain data line.
// Define GC_POLLER_RUMBLE_EN to add the rumble input (drives command bit 0).
module gc_poller
  import gc_pkg::*;
#(
  parameter int CLKS_PER_US   = 50,
  parameter int RX_TIMEOUT_US = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    poll_tick,
`ifdef GC_POLLER_RUMBLE_EN
  input  logic                    rumble,
`endif
  input  logic                    data_in,
  output logic                    data_oe,
  output logic [GC_RESP_BITS-1:0] buttons,
  output logic                    valid,
  output logic                    busy,
  output logic                    timeout
);

  localparam int T_SHORT = GC_SHORT_US * CLKS_PER_US;
  localparam int T_HALF  = GC_HALF_US * CLKS_PER_US;
  localparam int T_LONG  = GC_LONG_US * CLKS_PER_US;
  localparam int T_CELL  = GC_CELL_US * CLKS_PER_US;
  localparam int T_TO    = RX_TIMEOUT_US * CLKS_PER_US;
  localparam int T_MAX   = (T_CELL > T_TO) ? T_CELL : T_TO;
  localparam int CW      = $clog2(T_MAX + 1);
  localparam int RXW     = $clog2(GC_RESP_BITS);

  localparam logic [CW-1:0] C_SHORT   = CW'(T_SHORT);
  localparam logic [CW-1:0] C_LONG    = CW'(T_LONG);
  localparam logic [CW-1:0] C_STOP_M1 = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(T_HALF - 1);
  localparam logic [CW-1:0] C_CELL_M1 = CW'(T_CELL - 1);
  localparam logic [CW-1:0] C_TO      = CW'(T_TO);

  localparam logic [RXW-1:0] RX_LAST  = RXW'(GC_RESP_BITS - 1);
  localparam logic [4:0]     TX_FIRST = 5'(GC_CMD_BITS - 1);

  gc_state_t state;
  gc_state_t state_n;

  logic [CW-1:0]           cnt;
  logic [4:0]              bit_idx;
  logic [23:0]             cmd_q;
  logic [RXW-1:0]          rx_cnt;
  logic [GC_RESP_BITS-1:0] shreg;
  logic [GC_RESP_BITS-1:0] btn_q;
  logic                    tick_d;
  logic                    armed;

  logic ds;
  logic fall;
  logic req;
  logic tx_bit;
  logic cell_end;
  logic stop_end;
  logic samp;
  logic expire;
  logic cnt_clr;
  logic cmd_lsb;

  gc_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .data_s  (ds),
    .fall    (fall)
  );

`ifdef GC_POLLER_RUMBLE_EN
  assign cmd_lsb = rumble;
`else
  assign cmd_lsb = GC_POLL_CMD[0];
`endif

  // armed blocks a poll until poll_tick has been seen low after reset
  assign req      = poll_tick & ~tick_d & armed;
  assign tx_bit   = cmd_q[bit_idx];
  assign cell_end = (cnt == C_CELL_M1);
  assign stop_end = (cnt == C_STOP_M1);
  assign samp     = (cnt == C_HALF_M1);
  assign expire   = ((state == RX_WAIT) || (state == RX_BIT))
                    && (cnt == C_TO) && !fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = TX_BIT;
      TX_BIT:  if (cell_end && bit_idx == '0) state_n = TX_STOP;
      TX_STOP: if (stop_end) state_n = RX_WAIT;
      RX_WAIT: begin
        if (fall)        state_n = RX_BIT;
        else if (expire) state_n = IDLE;
      end
      RX_BIT: begin
        if (expire)                         state_n = IDLE;
        else if (samp && rx_cnt == RX_LAST) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    data_oe = 1'b0;
    unique case (state)
      TX_BIT:  data_oe = (cnt < (tx_bit ? C_SHORT : C_LONG));
      TX_STOP: data_oe = 1'b1;
      default: data_oe = 1'b0;
    endcase
    busy    = (state != IDLE);
    valid   = (state == DONE);
    timeout = expire;
    buttons = (state == DONE) ? shreg : btn_q;
  end

  // every falling edge in RX_BIT restarts the bit and the gap timer
  assign cnt_clr = (state_n != state)
                 || (state == IDLE)
                 || ((state == TX_BIT) && cell_end)
                 || ((state == RX_BIT) && fall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      cmd_q   <= '0;
      rx_cnt  <= '0;
      shreg   <= '0;
      btn_q   <= '0;
      tick_d  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      tick_d <= poll_tick;
      if (!poll_tick) armed <= 1'b1;
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if ((state == IDLE) && req) begin
        cmd_q   <= {GC_POLL_CMD[23:1], cmd_lsb};
        bit_idx <= TX_FIRST;
        rx_cnt  <= '0;
      end
      if ((state == TX_BIT) && cell_end) bit_idx <= bit_idx - 1'b1;
      if ((state == RX_BIT) && samp) begin
        shreg  <= {shreg[GC_RESP_BITS-2:0], ds};
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (state == DONE) btn_q <= shreg;
    end
  end

endmodule

// File: tb/tb_gc_poller.sv
// tb_gc_poller: scoreboard bench with a line monitor and controller model.
// Build with GC_POLLER_RUMBLE_EN to also exercise the rumble command bit.
module tb_gc_poller;

  typedef struct {
    bit          is_to;
    logic [63:0] val;
    bit          chk_t;
  } ev_t;

  localparam logic [63:0] RESP1 = 64'h0080_8080_8080_0000;
  localparam logic [63:0] RESP2 = 64'hA5C3_0F1E_1234_5678;

  logic        clk;
  logic        reset;
  logic        poll_tick;
  logic        rum;
  logic        data_in;
  logic        data_oe;
  logic [63:0] buttons;
  logic        valid;
  logic        busy;
  logic        timeout;
  logic        mdl_low;

  int n_cmp;
  int n_err;
  int cyc;
  int stop_cyc;
  int tx_done_cnt;

  ev_t         sb[$];
  logic [23:0] cq[$];

  assign data_in = ~(data_oe | mdl_low);

  gc_poller dut (
    .clk       (clk),
    .reset     (reset),
    .poll_tick (poll_tick),
`ifdef GC_POLLER_RUMBLE_EN
    .rumble    (rum),
`endif
    .data_in   (data_in),
    .data_oe   (data_oe),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input bit is_to, input logic [63:0] v,
                         input bit ct);
    ev_t e;
    e.is_to = is_to;
    e.val   = v;
    e.chk_t = ct;
    sb.push_back(e);
  endtask

  // line monitor: decodes the command and checks valid/timeout events
  initial begin
    logic        prev;
    logic        busy_chk;
    int          lo;
    int          hi;
    int          n;
    logic [24:0] w;
    ev_t         e;
    prev = 1'b0; busy_chk = 1'b0;
    lo = 0; hi = 0; n = 0; w = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev = 1'b0; busy_chk = 1'b0;
        lo = 0; hi = 0; n = 0;
      end else begin
        if (data_oe && !prev) begin
          if (n == 2) check("tx_b22_high", hi, 150);
          lo = 0;
        end
        if (!data_oe && prev) begin
          w = {w[23:0], (lo < 100)};
          if (n == 0) check("tx_b23_low", lo, 150);
          if (n == 1) check("tx_b22_low", lo, 50);
          n++;
          hi = 0;
          if (n == 25) begin
            check("tx_stop_low", lo, 50);
            if (cq.size() == 0) check("tx_expected", cq.size(), 1);
            else check("tx_cmd", w[24:1], cq.pop_front());
            n = 0;
            stop_cyc = cyc;
            tx_done_cnt++;
          end
        end
        if (data_oe) lo++;
        else         hi++;
        prev = data_oe;

        if (busy_chk) begin
          check("busy_after_valid", busy, 0);
          busy_chk = 1'b0;
        end
        if (valid) begin
          busy_chk = 1'b1;
          if (sb.size() == 0) check("valid_expected", sb.size(), 1);
          else begin
            e = sb.pop_front();
            check("ev_is_valid", e.is_to, 0);
            check("valid_buttons", buttons, e.val);
          end
        end
        if (timeout) begin
          if (sb.size() == 0) check("to_expected", sb.size(), 1);
          else begin
            e = sb.pop_front();
            check("ev_is_timeout", e.is_to, 1);
            check("to_buttons_kept", buttons, e.val);
            if (e.chk_t) check("to_delay", cyc - stop_cyc, 5000);
          end
        end
      end
    end
  end

  task automatic do_poll();
    logic [23:0] c;
    c = 24'h400300;
    c[0] = rum;
    poll_tick = 1'b0;
    repeat (3) @(negedge clk);
    cq.push_back(c);
    poll_tick = 1'b1;
    @(negedge clk);
    check("oe_latency", data_oe, 1);
  endtask

  task automatic wait_tx();
    int start;
    start = tx_done_cnt;
    for (int i = 0; i < 6000 && tx_done_cnt == start; i++)
      @(negedge clk);
    check("tx_done", tx_done_cnt != start, 1);
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++)
      @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic quiet(input string tag, input int ncyc);
    logic acc;
    acc = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      acc = acc | busy | data_oe | valid | timeout;
    end
    check(tag, acc, 0);
  endtask

  // controller model: poke issues a second poll edge mid-response
  task automatic send_resp(input logic [63:0] wd, input int nbits,
                           input bit poke);
    logic b;
    repeat (100) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = wd[63-i];
      if (poke && i == 10) poll_tick = 1'b0;
      if (poke && i == 12) poll_tick = 1'b1;
      mdl_low = 1'b1;
      repeat (b ? 50 : 150) @(negedge clk);
      mdl_low = 1'b0;
      repeat (b ? 150 : 50) @(negedge clk);
    end
    if (nbits == 64) begin
      mdl_low = 1'b1;
      repeat (50) @(negedge clk);
      mdl_low = 1'b0;
    end
  endtask

  initial begin
    int txs;
    n_cmp = 0; n_err = 0; cyc = 0; stop_cyc = 0; tx_done_cnt = 0;
    reset = 1'b0;
    poll_tick = 1'b1;
    rum = 1'b0;
    mdl_low = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {data_oe, valid, busy, timeout}, 0);
    check("rst_buttons", buttons, 0);

    reset = 1'b1;
    quiet("no_poll_held_high", 50);

    push_ev(1'b1, 64'h0, 1'b1);
    do_poll();
    wait_tx();
    wait_sb(6000);
    check("buttons_zero", buttons, 0);

    push_ev(1'b0, RESP1, 1'b0);
    do_poll();
    wait_tx();
    txs = tx_done_cnt;
    send_resp(RESP1, 64, 1'b1);
    wait_sb(2000);
    quiet("no_poll_after_ignored", 400);
    check("tx_count", tx_done_cnt - txs, 0);

    do_poll();
    repeat (410) @(negedge clk);
    check("oe_before_rst", data_oe, 1);
    reset = 1'b0;
    #1;
    check("oe_async_rst", data_oe, 0);
    check("busy_async_rst", busy, 0);
    cq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    quiet("no_poll_after_rst", 300);
    check("buttons_after_rst", buttons, 0);

    push_ev(1'b0, RESP1, 1'b0);
    do_poll();
    wait_tx();
    send_resp(RESP1, 64, 1'b0);
    wait_sb(2000);

    push_ev(1'b1, RESP1, 1'b0);
    do_poll();
    wait_tx();
    send_resp(RESP2, 30, 1'b0);
    wait_sb(6000);
    check("buttons_kept", buttons, RESP1);

`ifdef GC_POLLER_RUMBLE_EN
    rum = 1'b1;
    do_poll();
    wait_tx();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rum = 1'b0;
    do_poll();
    wait_tx();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
`endif

    repeat (20) @(negedge clk);
    check("queues_empty", sb.size() + cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gc_poller.md
GC_POLLER -- requirements
Module: gc_poller

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 50, meaning clk cycles per microsecond (minimum 8).
REQ-002 SHALL have parameter RX_TIMEOUT_US, default 100, meaning microseconds allowed from end of command to first response falling edge.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port poll_tick  input  1  divided poll-rate clock, synchronous to clk; each rising edge requests one poll.
REQ-006 SHALL have port data_in  input  1  controller data line as seen at the pad; asynchronous.
REQ-007 SHALL have port data_oe  output  1  1 = drive the line low, 0 = release it (open-drain).
REQ-008 SHALL have port buttons  output  64  last good controller response, MSB is the first bit received.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when buttons has been updated.
REQ-010 SHALL have port busy  output  1  high from poll start until DONE/timeout completes.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when no response arrives within RX_TIMEOUT_US.

Function
REQ-012 SHALL detect a poll request as poll_tick==1 while its 1-cycle-delayed copy is 0; data_oe SHALL assert on the following cycle.
REQ-013 SHALL ignore poll requests while busy; they are neither queued nor counted.
REQ-014 SHALL transmit the 24-bit command 0x400300 MSB first, followed by one stop bit.
REQ-015 SHALL use a 4 us bit cell: "0" = 3 us low + 1 us released; "1" = 1 us low + 3 us released; stop = 1 us low, then release.
REQ-016 SHALL pass data_in through a 2-flop synchronizer before any use; data_oe SHALL stay 0 whenever not transmitting.
REQ-017 SHALL implement states IDLE -> TX_BIT -> TX_STOP -> RX_WAIT -> RX_BIT -> DONE -> IDLE.
REQ-018 In RX_WAIT and RX_BIT, each synchronized falling edge SHALL start a bit; the line SHALL be sampled 2 us after that edge, with high = 1 and low = 0.
REQ-019 SHALL leave RX_BIT for DONE after 64 bits are received; the trailing stop bit SHALL be ignored.
REQ-020 The RX_WAIT timeout counter SHALL start at the end of the stop bit; on expiry it SHALL pulse timeout, return to IDLE, and leave buttons unchanged.
REQ-021 An RX_BIT gap longer than RX_TIMEOUT_US between falling edges SHALL be handled exactly as REQ-020.
REQ-022 In DONE, buttons SHALL load the shift register and valid SHALL pulse in the same cycle; the next cycle SHALL be IDLE with busy=0.
REQ-023 All timing counters SHALL be wide enough for 4*CLKS_PER_US and RX_TIMEOUT_US*CLKS_PER_US, and SHALL reset to 0 on every state entry.

Reset
REQ-024 When reset is low: state=IDLE, data_oe=0, buttons=0, valid=0, busy=0, timeout=0, and synchronizer and edge registers = 0, all immediately (asynchronous).
REQ-025 Reset asserted mid-transaction SHALL abort it with no valid or timeout pulse; the line SHALL be released at once.
REQ-026 After reset deasserts, the first poll SHALL require a fresh 0->1 transition of poll_tick.

Configuration
REQ-027 With macro GC_POLLER_RUMBLE_EN defined, SHALL add input rumble (1 bit), sampled at poll start, driving command bit 0 (0x400301 when 1).
REQ-028 Without GC_POLLER_RUMBLE_EN, SHALL have no rumble port, and command bit 0 SHALL be 0.

Structure
REQ-029 Package gc_pkg SHALL hold: state enum, the GC_POLL_CMD constant (0x400300), bit-cell constants in microseconds (1, 2, 3, 4), and the response width (64).
REQ-030 Sub-module gc_sync SHALL contain the 2-flop synchronizer plus falling-edge detector for data_in.

Verification
REQ-031 poll_tick rises with no controller model -> 0x400300 on the line (bit 1 = 50 clk low / 150 high, bit 0 = 150 low / 50 high at 50 MHz) -> timeout pulse 5000 clk after stop release; buttons stays 0.
REQ-032 Controller model replies 0x0080_8080_8080_0000 -> valid pulse with buttons = 0x0080808080800000, busy falls the next cycle.
REQ-033 Second poll_tick rising edge during RX_BIT -> ignored; exactly one valid pulse, and no transaction starts afterwards until the next edge.
REQ-034 reset pulled low mid-TX_BIT while data_oe=1 -> data_oe=0 in the same cycle, no valid or timeout pulse, and poll_tick held high afterwards starts no poll.
REQ-035 Model stops after 30 response bits -> timeout pulse; the prior buttons value is retained.
REQ-036 GC_POLLER_RUMBLE_EN defined and rumble=1 -> 0x400301 transmitted; rumble=0 -> 0x400300.
